// File: rtl/multdiv_pkg.sv
// multdiv_pkg: states, op codes and latency constants for multdiv_iter; MULTDIV_RADIX4_EN selects radix-4 Booth
package multdiv_pkg;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;
`ifdef MULTDIV_RADIX4_EN
  localparam int BOOTH_SHIFT = 2;
`else
  localparam int BOOTH_SHIFT = 1;
`endif
  localparam int MUL_LAT = 32 / BOOTH_SHIFT + 1;
  localparam int DIV_LAT = 34;
  localparam int MUL_ITERS = MUL_LAT - 1;
  localparam int DIV_ITERS = DIV_LAT - 2;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps the multiplier bit window to add/subtract/double controls; MULTDIV_RADIX4_EN selects radix-4
module booth_recoder
  import multdiv_pkg::*;
(
  input  logic [BOOTH_SHIFT:0] win,
  output logic                 en,
  output logic                 neg,
  output logic                 dbl
);
`ifdef MULTDIV_RADIX4_EN
  assign en  = !(&win || ~|win);
  assign neg = win[2];
  assign dbl = (win == 3'b011) || (win == 3'b100);
`else
  assign en  = win[1] ^ win[0];
  assign neg = win[1];
  assign dbl = 1'b0;
`endif
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed Booth multiplier / restoring divider; MULTDIV_RADIX4_EN enables radix-4 multiply
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t state_q, state_d;
  op_t op;
  logic [5:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] hi_q, hi_d, addend, sum;
  logic [WIDTH-1:0] lo_q, lo_d, m_q, m_d, result_q, result_d, a_abs, b_abs, quo;
  logic qm1_q, qm1_d, neg_q, neg_d, dexc_q, dexc_d, exc_q, exc_d, rdy_q, rdy_d;
  logic b_en, b_neg, b_dbl, start, ovf;
  logic [2*WIDTH+1:0] sh;
  logic [WIDTH:0] t, diff;

  booth_recoder u_booth (
    .win ({lo_q[BOOTH_SHIFT-1:0], qm1_q}),
    .en  (b_en),
    .neg (b_neg),
    .dbl (b_dbl)
  );

  assign start  = ctrl_MULT | ctrl_DIV;
  assign op     = ctrl_MULT ? OP_MUL : OP_DIV;
  assign a_abs  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign addend = b_dbl ? {m_q[WIDTH-1], m_q, 1'b0} : {{2{m_q[WIDTH-1]}}, m_q};
  assign sum    = !b_en ? hi_q : b_neg ? hi_q - addend : hi_q + addend;
  assign sh     = $signed({sum, lo_q}) >>> BOOTH_SHIFT;
  assign t      = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign diff   = t - {1'b0, m_q};
  assign quo    = neg_q ? -lo_q : lo_q;
  assign ovf    = !(&{hi_q[WIDTH-1:0], lo_q[WIDTH-1]} || ~|{hi_q[WIDTH-1:0], lo_q[WIDTH-1]});

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = state_q != IDLE;

  // next-state and datapath: any start restarts; MUL/DIV iterate, FIX applies sign, results latch with RDY
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    qm1_d    = qm1_q;
    neg_d    = neg_q;
    dexc_d   = dexc_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (start) begin
      state_d = (op == OP_MUL) ? MUL : DIV;
      cnt_d   = '0;
      hi_d    = '0;
      qm1_d   = 1'b0;
      m_d     = (op == OP_MUL) ? data_operandA : b_abs;
      lo_d    = (op == OP_MUL) ? data_operandB : a_abs;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dexc_d  = (data_operandB == '0) || (data_operandA == INT_MIN && &data_operandB);
    end else begin
      case (state_q)
        MUL: begin
          if (cnt_q == 6'(MUL_ITERS)) begin
            state_d  = DONE;
            rdy_d    = 1'b1;
            result_d = lo_q;
            exc_d    = ovf;
          end else begin
            hi_d  = sh[2*WIDTH+1:WIDTH];
            lo_d  = sh[WIDTH-1:0];
            qm1_d = lo_q[BOOTH_SHIFT-1];
            cnt_d = cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == 6'(DIV_ITERS)) begin
            state_d = FIX;
          end else begin
            hi_d  = {1'b0, diff[WIDTH] ? t : diff};
            lo_d  = {lo_q[WIDTH-2:0], !diff[WIDTH]};
            cnt_d = cnt_q + 1'b1;
          end
        end
        FIX: begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = (m_q == '0) ? '0 : quo;
          exc_d    = dexc_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      dexc_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      neg_q    <= neg_d;
      dexc_q   <= dexc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: scoreboard bench for multdiv_iter; MULTDIV_RADIX4_EN selects the 17-edge multiply latency
module tb_multdiv_iter;
`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 34;
  localparam logic [31:0] IMIN = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, busy;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multdiv_iter dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic mul, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = !(&p[63:31] || ~|p[63:31]);
      e.lat = 8'(MUL_LAT);
    end else begin
      e.lat = 8'(DIV_LAT);
      if (b == 32'h0) begin
        e.res = '0;
        e.exc = 1'b1;
      end else if (a == IMIN && b == 32'hFFFF_FFFF) begin
        e.res = IMIN;
        e.exc = 1'b1;
      end else begin
        e.res = $signed(a) / $signed(b);
        e.exc = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b, input logic push);
    @(negedge clk);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = mul;
    ctrl_DIV = div;
    if (push) sb.push_back(model(mul, a, b));
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    exp_t e;
    n = 0;
    e = '0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) n = i;
    end
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_latency"}, n, e.lat);
    check({tag, "_result"}, data_result, e.res);
    check({tag, "_exc"}, data_exception, e.exc);
    check({tag, "_busy_rdy"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_rdy_one_cycle"}, data_resultRDY, 0);
    check({tag, "_result_hold"}, data_result, e.res);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    clr_n = 1'b1;
    start_op(1, 0, 32'd7, 32'hFFFF_FFFA, 1);
    wait_rdy("mul_basic");
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1);
    wait_rdy("mul_ovf");
    start_op(1, 0, IMIN, 32'd1, 1);
    wait_rdy("mul_intmin");
    start_op(0, 1, 32'hFFFF_FFEF, 32'd5, 1);
    wait_rdy("div_basic");
    start_op(0, 1, 32'd123, 32'd0, 1);
    wait_rdy("div_zero");
    start_op(0, 1, IMIN, 32'hFFFF_FFFF, 1);
    wait_rdy("div_ovf");
    start_op(1, 0, 32'd3, 32'd4, 0);
    seen = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      seen += int'(data_resultRDY);
    end
    check("restart_no_rdy", seen, 0);
    start_op(0, 1, 32'd100, 32'd7, 1);
    wait_rdy("restart_div");
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      start_op(i[0], !i[0], a, b, 1);
      wait_rdy(i[0] ? "rand_mul" : "rand_div");
    end
    start_op(1, 1, 32'd5, 32'd9, 1);
    wait_rdy("simul_start");
    start_op(0, 1, 32'd1000, 32'd3, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_result", data_result, 0);
    check("midrst_exc", data_exception, 0);
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen += int'(data_resultRDY);
    end
    check("midrst_no_rdy", seen, 0);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end
endmodule
